// File: rtl/bnn_classifier_core_pkg.sv
// Shared types, sizes and helpers for the binarised MLP classifier.
// Holds the default geometry, FSM state encoding, config-map region constants
// and the XNOR-popcount helpers used by the datapath.
package bnn_classifier_core_pkg;

   localparam int unsigned N_FEAT = 4;
   localparam int unsigned FEAT_W = 4;
   localparam int unsigned THRESH = 8;
   localparam int unsigned N_HID  = 8;
   localparam int unsigned N_CLS  = 4;
   localparam int unsigned BIAS_W = 4;
   localparam int unsigned CFG_W  = 16;

   // Config map: W_H at [0,N_HID), B_H at [BH_BASE,WO_BASE), W_O at [WO_BASE,CFG_WORDS)
   localparam int unsigned BH_BASE   = N_HID;
   localparam int unsigned WO_BASE   = 2 * N_HID;
   localparam int unsigned CFG_WORDS = 2 * N_HID + N_CLS;

   localparam int unsigned ADDR_W    = $clog2(CFG_WORDS);
   localparam int unsigned CLS_W     = $clog2(N_CLS);
   localparam int unsigned SCORE_W   = $clog2(N_HID + 1);
   localparam int unsigned HID_IDX_W = $clog2(N_HID);
   localparam int unsigned IDX_W     = (HID_IDX_W > CLS_W) ? HID_IDX_W : CLS_W;
   localparam int unsigned FPOP_W    = $clog2(N_FEAT + 1);
   localparam int unsigned SUM_W     = FPOP_W + BIAS_W + 1;

   // Widest config field actually stored; upper cfg_wdata bits are ignored
   localparam int unsigned DATA_W_0  = (N_FEAT > N_HID) ? N_FEAT : N_HID;
   localparam int unsigned DATA_W    = (DATA_W_0 > BIAS_W) ? DATA_W_0 : BIAS_W;

   typedef logic [N_FEAT-1:0] wh_t;
   typedef logic [BIAS_W-1:0] bh_t;
   typedef logic [N_HID-1:0]  wo_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HID  = 2'd1,
      ST_OUT  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      RG_WH   = 2'd0,
      RG_BH   = 2'd1,
      RG_WO   = 2'd2,
      RG_NONE = 2'd3
   } region_t;

   // Map a config address onto its register region
   function automatic region_t decode_region(input logic [ADDR_W-1:0] a);
      if (32'(a) < BH_BASE)   return RG_WH;
      if (32'(a) < WO_BASE)   return RG_BH;
      if (32'(a) < CFG_WORDS) return RG_WO;
      return RG_NONE;
   endfunction

   // Agreement count between input bits and hidden weights
   function automatic logic [FPOP_W-1:0] xnor_popcount_feat(input wh_t a, input wh_t b);
      logic [N_FEAT-1:0] m;
      logic [FPOP_W-1:0] cnt;
      m   = ~(a ^ b);
      cnt = '0;
      for (int i = 0; i < N_FEAT; i++) cnt = cnt + FPOP_W'(m[i]);
      return cnt;
   endfunction

   // Agreement count between hidden activations and output weights
   function automatic logic [SCORE_W-1:0] xnor_popcount_hid(input wo_t a, input wo_t b);
      logic [N_HID-1:0]   m;
      logic [SCORE_W-1:0] cnt;
      m   = ~(a ^ b);
      cnt = '0;
      for (int i = 0; i < N_HID; i++) cnt = cnt + SCORE_W'(m[i]);
      return cnt;
   endfunction

endpackage

// File: rtl/bnn_classifier_core_if.sv
// Stream, config and result bundle of the classifier.
// master: feature packer / config host / result consumer side.
// slave : the classifier core.
interface bnn_classifier_core_if;
   import bnn_classifier_core_pkg::*;

   logic                     in_valid;
   logic                     in_ready;
   logic [N_FEAT*FEAT_W-1:0] in_feat;
   logic                     cfg_we;
   logic [ADDR_W-1:0]        cfg_addr;
   logic [CFG_W-1:0]         cfg_wdata;
   logic                     cfg_err;
   logic                     out_valid;
   logic                     out_ready;
   logic [CLS_W-1:0]         out_class;
   logic [SCORE_W-1:0]       out_score;
   logic [N_HID-1:0]         out_hidden;
   logic                     busy;

   modport master (
      output in_valid, in_feat, cfg_we, cfg_addr, cfg_wdata, out_ready,
      input  in_ready, cfg_err, out_valid, out_class, out_score, out_hidden, busy
   );

   modport slave (
      input  in_valid, in_feat, cfg_we, cfg_addr, cfg_wdata, out_ready,
      output in_ready, cfg_err, out_valid, out_class, out_score, out_hidden, busy
   );

endinterface

// File: rtl/bnn_weight_regs.sv
// Runtime-programmable weight/bias register file with region decode.
// Ports: clk, rst (sync, active-high); idle/accept from the core FSM;
// cfg_we/cfg_addr/cfg_wdata write port; cfg_err one-cycle reject pulse;
// w_h/b_h/w_o register contents.
// A write landing in the same cycle as an input accept is parked and
// committed on the next idle cycle, so the running inference sees the old
// configuration.
module bnn_weight_regs
   import bnn_classifier_core_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              idle,
   input  logic              accept,
   input  logic              cfg_we,
   input  logic [ADDR_W-1:0] cfg_addr,
   input  logic [CFG_W-1:0]  cfg_wdata,
   output logic              cfg_err,
   output wh_t               w_h [N_HID],
   output bh_t               b_h [N_HID],
   output wo_t               w_o [N_CLS]
);

   logic              pend_v_q;
   logic [ADDR_W-1:0] pend_addr_q;
   logic [DATA_W-1:0] pend_data_q;
   logic [DATA_W-1:0] wdata_c;
   region_t           new_rg_c;
   region_t           pend_rg_c;
   logic              unused_ok;

   assign wdata_c   = cfg_wdata[DATA_W-1:0];
   assign unused_ok = ^cfg_wdata[CFG_W-1:DATA_W];
   assign new_rg_c  = decode_region(cfg_addr);
   assign pend_rg_c = decode_region(pend_addr_q);

   // Register file, deferred-write slot and reject pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int n = 0; n < N_HID; n++) begin
            w_h[n] <= '0;
            b_h[n] <= '0;
         end
         for (int c = 0; c < N_CLS; c++) w_o[c] <= '0;
         pend_v_q    <= 1'b0;
         pend_addr_q <= '0;
         pend_data_q <= '0;
         cfg_err     <= 1'b0;
      end else begin
         cfg_err <= cfg_we && (!idle || (new_rg_c == RG_NONE));

         // Commit a parked write first so a fresh write to the same word wins
         if (pend_v_q && idle) begin
            pend_v_q <= 1'b0;
            case (pend_rg_c)
               RG_WH:   w_h[HID_IDX_W'(pend_addr_q)] <= pend_data_q[N_FEAT-1:0];
               RG_BH:   b_h[HID_IDX_W'(pend_addr_q - ADDR_W'(BH_BASE))] <= pend_data_q[BIAS_W-1:0];
               RG_WO:   w_o[CLS_W'(pend_addr_q - ADDR_W'(WO_BASE))] <= pend_data_q[N_HID-1:0];
               default: ;
            endcase
         end

         if (cfg_we && idle && (new_rg_c != RG_NONE)) begin
            if (accept) begin
               pend_v_q    <= 1'b1;
               pend_addr_q <= cfg_addr;
               pend_data_q <= wdata_c;
            end else begin
               case (new_rg_c)
                  RG_WH:   w_h[HID_IDX_W'(cfg_addr)] <= wdata_c[N_FEAT-1:0];
                  RG_BH:   b_h[HID_IDX_W'(cfg_addr - ADDR_W'(BH_BASE))] <= wdata_c[BIAS_W-1:0];
                  RG_WO:   w_o[CLS_W'(cfg_addr - ADDR_W'(WO_BASE))] <= wdata_c[N_HID-1:0];
                  default: ;
               endcase
            end
         end
      end
   end

endmodule

// File: rtl/bnn_classifier_core.sv
// Binarised MLP classifier: thresholded features -> sign hidden layer ->
// popcount class scores -> argmax, evaluated one neuron per cycle.
// Ports: clk, rst (sync, active-high); bus (slave) carrying the input
// stream, config write port, result stream and busy flag.
module bnn_classifier_core
   import bnn_classifier_core_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   bnn_classifier_core_if.slave  bus
);

   state_t             state_q, state_d;
   logic               accept_c, last_hid_c, last_cls_c;
   logic [N_FEAT-1:0]  bin_x_c, x_q;
   logic [N_HID-1:0]   h_q;
   logic [IDX_W-1:0]   idx_q;
   logic [SUM_W-1:0]   hid_sum_c;
   logic [SCORE_W-1:0] out_pop_c, best_score_q;
   logic [CLS_W-1:0]   best_cls_q;

   logic               in_ready_q, busy_q, out_valid_q;
   logic [CLS_W-1:0]   out_class_q;
   logic [SCORE_W-1:0] out_score_q;
   logic [N_HID-1:0]   out_hidden_q;

   wh_t w_h [N_HID];
   bh_t b_h [N_HID];
   wo_t w_o [N_CLS];

   bnn_weight_regs u_regs (
      .clk       (clk),
      .rst       (rst),
      .idle      (state_q == ST_IDLE),
      .accept    (accept_c),
      .cfg_we    (bus.cfg_we),
      .cfg_addr  (bus.cfg_addr),
      .cfg_wdata (bus.cfg_wdata),
      .cfg_err   (bus.cfg_err),
      .w_h       (w_h),
      .b_h       (b_h),
      .w_o       (w_o)
   );

   assign bus.in_ready   = in_ready_q;
   assign bus.busy       = busy_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_class  = out_class_q;
   assign bus.out_score  = out_score_q;
   assign bus.out_hidden = out_hidden_q;

   // Binarise features and evaluate the currently indexed neurons
   always_comb begin
      wh_t wh_sel;
      bh_t bh_sel;
      logic [FPOP_W-1:0] fpop;
      bin_x_c = '0;
      for (int i = 0; i < N_FEAT; i++)
         bin_x_c[i] = bus.in_feat[i*FEAT_W +: FEAT_W] >= FEAT_W'(THRESH);
      wh_sel     = w_h[HID_IDX_W'(idx_q)];
      bh_sel     = b_h[HID_IDX_W'(idx_q)];
      fpop       = xnor_popcount_feat(x_q, wh_sel);
      // Zero-extended popcount plus sign-extended bias; MSB is the sign
      hid_sum_c  = {{(SUM_W-FPOP_W){1'b0}}, fpop} + {{(SUM_W-BIAS_W){bh_sel[BIAS_W-1]}}, bh_sel};
      out_pop_c  = xnor_popcount_hid(h_q, w_o[CLS_W'(idx_q)]);
      last_hid_c = (idx_q == IDX_W'(N_HID - 1));
      last_cls_c = (idx_q == IDX_W'(N_CLS - 1));
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d  = state_q;
      accept_c = 1'b0;
      case (state_q)
         ST_IDLE: if (bus.in_valid && in_ready_q) begin
            accept_c = 1'b1;
            state_d  = ST_HID;
         end
         ST_HID:  if (last_hid_c) state_d = ST_OUT;
         ST_OUT:  if (last_cls_c) state_d = ST_DONE;
         ST_DONE: if (out_valid_q && bus.out_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Datapath and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         in_ready_q   <= 1'b1;
         busy_q       <= 1'b0;
         out_valid_q  <= 1'b0;
         out_class_q  <= '0;
         out_score_q  <= '0;
         out_hidden_q <= '0;
         x_q          <= '0;
         h_q          <= '0;
         idx_q        <= '0;
         best_score_q <= '0;
         best_cls_q   <= '0;
      end else begin
         in_ready_q <= (state_d == ST_IDLE);
         busy_q     <= (state_d != ST_IDLE);
         case (state_q)
            ST_IDLE: if (accept_c) begin
               x_q   <= bin_x_c;
               h_q   <= '0;
               idx_q <= '0;
            end
            ST_HID: begin
               h_q[HID_IDX_W'(idx_q)] <= ~hid_sum_c[SUM_W-1];
               idx_q <= last_hid_c ? '0 : idx_q + IDX_W'(1);
            end
            ST_OUT: begin
               // Strict greater-than keeps the lowest index on ties
               if ((idx_q == '0) || (out_pop_c > best_score_q)) begin
                  best_score_q <= out_pop_c;
                  best_cls_q   <= CLS_W'(idx_q);
               end
               idx_q <= last_cls_c ? '0 : idx_q + IDX_W'(1);
            end
            ST_DONE: begin
               if (!out_valid_q) begin
                  out_valid_q  <= 1'b1;
                  out_class_q  <= best_cls_q;
                  out_score_q  <= best_score_q;
                  out_hidden_q <= h_q;
               end else if (bus.out_ready) begin
                  out_valid_q  <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bnn_classifier_core.sv
// Directed self-checking bench for bnn_classifier_core.
module tb_bnn_classifier_core;
   import bnn_classifier_core_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   bnn_classifier_core_if bus ();

   bnn_classifier_core dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic cfg_write(input logic [ADDR_W-1:0] a, input logic [CFG_W-1:0] d);
      bus.cfg_we    = 1'b1;
      bus.cfg_addr  = a;
      bus.cfg_wdata = d;
      tick();
      bus.cfg_we    = 1'b0;
   endtask

   task automatic start(input logic [N_FEAT*FEAT_W-1:0] f);
      bus.in_feat  = f;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_out(output int cyc);
      cyc = 0;
      while (bus.out_valid !== 1'b1 && cyc < 40) begin
         tick();
         cyc++;
      end
   endtask

   task automatic consume();
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
      checks++; if (bus.cfg_err !== 1'b0) begin errors++; $display("FAIL rst_cfg_err: got %b want 0", bus.cfg_err); end
      checks++; if ({bus.out_class, bus.out_score, bus.out_hidden} !== '0) begin
         errors++; $display("FAIL rst_outputs: class %0d score %0d hidden %h want all 0", bus.out_class, bus.out_score, bus.out_hidden);
      end
   endtask

   task automatic test_default();
      int cyc;
      start(16'hFFFF);
      checks++; if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
         errors++; $display("FAIL dflt_busy: in_ready %b busy %b want 0/1", bus.in_ready, bus.busy);
      end
      wait_out(cyc);
      checks++; if (cyc != 13) begin errors++; $display("FAIL dflt_latency: got %0d want 13", cyc); end
      checks++; if (bus.out_hidden !== 8'hFF) begin errors++; $display("FAIL dflt_hidden: got %h want ff", bus.out_hidden); end
      checks++; if (bus.out_class !== 2'd0 || bus.out_score !== 4'd0) begin
         errors++; $display("FAIL dflt_result: class %0d score %0d want 0/0", bus.out_class, bus.out_score);
      end
      consume();
      checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         errors++; $display("FAIL dflt_handshake: out_valid %b in_ready %b want 0/1", bus.out_valid, bus.in_ready);
      end
   endtask

   task automatic test_class_select();
      int cyc;
      cfg_write(5'd18, 16'h00FF);
      checks++; if (bus.cfg_err !== 1'b0) begin errors++; $display("FAIL sel_cfg_err: got %b want 0", bus.cfg_err); end
      start(16'hFFFF);
      wait_out(cyc);
      checks++; if (cyc != 13 || bus.out_class !== 2'd2 || bus.out_score !== 4'd8) begin
         errors++; $display("FAIL sel_single: cyc %0d class %0d score %0d want 13/2/8", cyc, bus.out_class, bus.out_score);
      end
      consume();
      cfg_write(5'd17, 16'h00FF);
      cfg_write(5'd19, 16'h00FF);
      start(16'hFFFF);
      wait_out(cyc);
      checks++; if (cyc != 13 || bus.out_class !== 2'd1 || bus.out_score !== 4'd8) begin
         errors++; $display("FAIL sel_tie: cyc %0d class %0d score %0d want 13/1/8", cyc, bus.out_class, bus.out_score);
      end
      consume();
   endtask

   task automatic test_bias();
      int cyc;
      apply_reset();
      for (int n = 8; n < 12; n++) cfg_write(ADDR_W'(n), 16'h000F);
      cfg_write(5'd19, 16'h00F0);
      start(16'hFFFF);
      wait_out(cyc);
      checks++; if (bus.out_hidden !== 8'hF0) begin errors++; $display("FAIL bias_hidden: got %h want f0", bus.out_hidden); end
      checks++; if (cyc != 13 || bus.out_class !== 2'd3 || bus.out_score !== 4'd8) begin
         errors++; $display("FAIL bias_result: cyc %0d class %0d score %0d want 13/3/8", cyc, bus.out_class, bus.out_score);
      end
      consume();
   endtask

   task automatic test_threshold();
      int cyc;
      cfg_write(5'd0, 16'h0001);
      cfg_write(5'd8, 16'h000C);
      start(16'h7778);
      wait_out(cyc);
      checks++; if (bus.out_hidden !== 8'hFF || bus.out_class !== 2'd3 || bus.out_score !== 4'd4) begin
         errors++; $display("FAIL thr_at8: hidden %h class %0d score %0d want ff/3/4", bus.out_hidden, bus.out_class, bus.out_score);
      end
      consume();
      start(16'h7777);
      wait_out(cyc);
      checks++; if (bus.out_hidden !== 8'hFE || bus.out_class !== 2'd3 || bus.out_score !== 4'd5) begin
         errors++; $display("FAIL thr_at7: hidden %h class %0d score %0d want fe/3/5", bus.out_hidden, bus.out_class, bus.out_score);
      end
      consume();
   endtask

   task automatic test_cfg_same_cycle();
      int cyc;
      bus.in_feat   = 16'h7777;
      bus.in_valid  = 1'b1;
      bus.cfg_we    = 1'b1;
      bus.cfg_addr  = 5'd8;
      bus.cfg_wdata = 16'h0000;
      tick();
      bus.in_valid  = 1'b0;
      bus.cfg_we    = 1'b0;
      checks++; if (bus.cfg_err !== 1'b0) begin errors++; $display("FAIL same_cfg_err: got %b want 0", bus.cfg_err); end
      wait_out(cyc);
      checks++; if (bus.out_hidden !== 8'hFE || bus.out_score !== 4'd5) begin
         errors++; $display("FAIL same_old_cfg: hidden %h score %0d want fe/5", bus.out_hidden, bus.out_score);
      end
      consume();
      start(16'h7777);
      wait_out(cyc);
      checks++; if (bus.out_hidden !== 8'hFF || bus.out_class !== 2'd3 || bus.out_score !== 4'd4) begin
         errors++; $display("FAIL same_new_cfg: hidden %h class %0d score %0d want ff/3/4", bus.out_hidden, bus.out_class, bus.out_score);
      end
      consume();
   endtask

   task automatic test_backpressure();
      int cyc;
      int bad = 0;
      start(16'hFFFF);
      wait_out(cyc);
      checks++; if (bus.out_hidden !== 8'hF1 || bus.out_class !== 2'd3 || bus.out_score !== 4'd7) begin
         errors++; $display("FAIL bp_result: hidden %h class %0d score %0d want f1/3/7", bus.out_hidden, bus.out_class, bus.out_score);
      end
      bus.in_feat  = 16'h0000;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (bus.out_valid !== 1'b1 || bus.out_class !== 2'd3 || bus.out_score !== 4'd7 || bus.in_ready !== 1'b0) bad++;
      end
      bus.in_valid = 1'b0;
      checks++; if (bad != 0) begin errors++; $display("FAIL bp_hold: %0d unstable cycles want 0", bad); end
      consume();
      checks++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         errors++; $display("FAIL bp_release: busy %b in_ready %b out_valid %b want 0/1/0", bus.busy, bus.in_ready, bus.out_valid);
      end
   endtask

   task automatic test_cfg_busy();
      int cyc;
      apply_reset();
      start(16'hFFFF);
      tick();
      bus.cfg_we    = 1'b1;
      bus.cfg_addr  = 5'd16;
      bus.cfg_wdata = 16'h00FF;
      tick();
      bus.cfg_we    = 1'b0;
      checks++; if (bus.cfg_err !== 1'b1) begin errors++; $display("FAIL busy_err_pulse: got %b want 1", bus.cfg_err); end
      tick();
      checks++; if (bus.cfg_err !== 1'b0) begin errors++; $display("FAIL busy_err_clear: got %b want 0", bus.cfg_err); end
      wait_out(cyc);
      checks++; if (cyc != 10 || bus.out_class !== 2'd0 || bus.out_score !== 4'd0) begin
         errors++; $display("FAIL busy_no_write: cyc %0d class %0d score %0d want 10/0/0", cyc, bus.out_class, bus.out_score);
      end
      consume();
      cfg_write(5'd20, 16'h00FF);
      checks++; if (bus.cfg_err !== 1'b1) begin errors++; $display("FAIL oor_err_pulse: got %b want 1", bus.cfg_err); end
      tick();
      checks++; if (bus.cfg_err !== 1'b0) begin errors++; $display("FAIL oor_err_clear: got %b want 0", bus.cfg_err); end
      start(16'hFFFF);
      wait_out(cyc);
      checks++; if (cyc != 13 || bus.out_class !== 2'd0 || bus.out_score !== 4'd0) begin
         errors++; $display("FAIL oor_no_write: cyc %0d class %0d score %0d want 13/0/0", cyc, bus.out_class, bus.out_score);
      end
      consume();
   endtask

   task automatic test_reset_mid();
      int cyc;
      int seen = 0;
      cfg_write(5'd18, 16'h00FF);
      start(16'hFFFF);
      tick();
      tick();
      tick();
      checks++; if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
         errors++; $display("FAIL mid_pre: busy %b in_ready %b want 1/0", bus.busy, bus.in_ready);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
         errors++; $display("FAIL mid_abort: out_valid %b in_ready %b busy %b want 0/1/0", bus.out_valid, bus.in_ready, bus.busy);
      end
      for (int i = 0; i < 20; i++) begin
         tick();
         if (bus.out_valid !== 1'b0) seen++;
      end
      checks++; if (seen != 0) begin errors++; $display("FAIL mid_no_result: out_valid seen %0d cycles want 0", seen); end
      start(16'hFFFF);
      wait_out(cyc);
      checks++; if (cyc != 13 || bus.out_hidden !== 8'hFF || bus.out_class !== 2'd0 || bus.out_score !== 4'd0) begin
         errors++; $display("FAIL mid_weights_clear: cyc %0d hidden %h class %0d score %0d want 13/ff/0/0",
                            cyc, bus.out_hidden, bus.out_class, bus.out_score);
      end
      consume();
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_feat   = '0;
      bus.cfg_we    = 1'b0;
      bus.cfg_addr  = '0;
      bus.cfg_wdata = '0;
      bus.out_ready = 1'b0;
      tick();
      apply_reset();
      test_reset();
      test_default();
      test_class_select();
      test_bias();
      test_threshold();
      test_cfg_same_cycle();
      test_backpressure();
      test_cfg_busy();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
